// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for the system clock divider.
// Starts and stops the divided clock. New divide ratios arrive over a valid/ready handshake.
// A ratio received while running is held in a shadow register. It is applied only at a
// falling-edge boundary, so every output period uses a single ratio.
// Optional feature: define CLK_DIV_CTRL_EDGE_CNT_EN to add the edge_cnt rising-edge counter.
module clk_div_ctrl #(
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 24
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    ,
    parameter int EDGE_CNT_W  = 16
`endif
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    ,
    output logic [EDGE_CNT_W-1:0] edge_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] q_q, q_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             cfg_err_q, cfg_err_d;

    logic             at_limit;
    logic             cfg_xfer;
    logic             apply_shadow;

    assign at_limit = (q_q == div_q);
    // A shadowed ratio blocks further transfers until it has been applied.
    assign cfg_xfer = cfg_valid & ~pending_q;

    assign cfg_ready = ~pending_q;
    assign cfg_err   = cfg_err_q;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign busy      = (state_q != ST_IDLE);

    // State register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: stop beats start. While high, a stop drains to the natural falling edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) state_d = ST_RUN;
            end
            ST_RUN: begin
                // If stop arrives on a falling boundary, that edge completes the period now.
                if (stop) state_d = (clk_out_q && !at_limit) ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (at_limit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter, output clock, ratio shadowing and config handshake
    always_comb begin
        q_d          = q_q;
        clk_out_d    = clk_out_q;
        div_d        = div_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        cfg_err_d    = 1'b0;
        apply_shadow = 1'b0;

        if (state_q == ST_IDLE) begin
            q_d       = '0;
            clk_out_d = 1'b0;
        end else if (state_d == ST_IDLE) begin
            // Leaving to IDLE: park low and flush any pending ratio on this boundary.
            q_d          = '0;
            clk_out_d    = 1'b0;
            apply_shadow = 1'b1;
        end else if (at_limit) begin
            q_d          = '0;
            clk_out_d    = ~clk_out_q;
            apply_shadow = clk_out_q;
        end else begin
            q_d = q_q + CNT_W'(1);
        end

        if (apply_shadow && pending_q) begin
            div_d     = shadow_q;
            pending_d = 1'b0;
        end

        if (cfg_xfer) begin
            if (cfg_div == '0) begin
                cfg_err_d = 1'b1;
            end else if (state_q == ST_IDLE || state_d == ST_IDLE) begin
                // No period is in flight, so the ratio can take effect immediately.
                div_d = cfg_div;
            end else begin
                shadow_d  = cfg_div;
                pending_d = 1'b1;
            end
        end

        tick_d = clk_out_d & ~clk_out_q;
    end

    // Datapath registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            q_q       <= '0;
            div_q     <= CNT_W'(DEFAULT_DIV);
            shadow_q  <= '0;
            pending_q <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;

    assign edge_cnt = edge_cnt_q;

    // Rising-edge count: wraps naturally and restarts from zero on each IDLE->RUN.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (state_q == ST_IDLE && state_d == ST_RUN) begin
            edge_cnt_d = '0;
        end else if (tick_d) begin
            edge_cnt_d = edge_cnt_q + EDGE_CNT_W'(1);
        end
    end

    // Edge counter register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl. The stimulus pushes the expected clk_out half-period
// edges and the expected cfg_err pulses into queues. A monitor pops from these queues as
// the DUT produces them. Build with CLK_DIV_CTRL_EDGE_CNT_EN defined to include the
// edge_cnt scenario.
module tb_clk_div_ctrl;

    localparam int CNT_W = 26;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, stop, cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready, cfg_err, clk_out, tick, busy;
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    logic [7:0]       edge_cnt;
`endif

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .CNT_W(CNT_W),
        .DEFAULT_DIV(24)
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
        ,
        .EDGE_CNT_W(8)
`endif
    ) dut (
        .clk_in(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .cfg_valid(cfg_valid),
        .cfg_div(cfg_div),
        .cfg_ready(cfg_ready),
        .cfg_err(cfg_err),
        .clk_out(clk_out),
        .tick(tick),
        .busy(busy)
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
        ,
        .edge_cnt(edge_cnt)
`endif
    );

    typedef struct {
        logic lvl;
        int   len;
    } edge_t;

    edge_t exp_q[$];
    int    err_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_edge(input logic l, input int n);
        edge_t e;
        e.lvl = l;
        e.len = n;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_lvl(input logic l, input int budget, input string name);
        int n;
        n = 0;
        while (clk_out !== l && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (clk_out !== l) begin
            errors++;
            $display("FAIL %s: clk_out=%0b after %0d cycles, expected %0b", name, clk_out, n, l);
        end
    endtask

    // Monitor: compares every clk_out edge, tick and cfg_err pulse against the queues.
    initial begin
        logic  prev_clk;
        logic  prev_busy;
        int    ref_c;
        edge_t e;
        prev_clk  = 1'b0;
        prev_busy = 1'b0;
        ref_c     = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_clk  = 1'b0;
                prev_busy = 1'b0;
                continue;
            end
            if (busy && !prev_busy) ref_c = cyc;
            if (clk_out !== prev_clk) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL edge_unexpected: clk_out went to %0b at cycle %0d, expected no edge",
                             clk_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("edge_level", int'(clk_out), int'(e.lvl));
                    check("half_period", cyc - ref_c, e.len);
                end
                ref_c = cyc;
            end
            if (tick || (clk_out && !prev_clk))
                check("tick_on_rise", int'(tick), int'(clk_out && !prev_clk));
            if (cfg_err) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL cfg_err_unexpected: cfg_err=1 at cycle %0d, expected 0", cyc);
                end else begin
                    void'(err_q.pop_front());
                end
            end
            prev_clk  = clk_out;
            prev_busy = busy;
        end
    end

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;

        // Reset state
        step(3);
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        rst_n = 1'b1;
        step(1);

        // Default run: first rise 25 cycles after RUN entry, then 25-cycle halves
        push_edge(1'b1, 25); push_edge(1'b0, 25); push_edge(1'b1, 25);
        push_edge(1'b0, 25); push_edge(1'b1, 25);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("busy_run", int'(busy), 1);
        wait_lvl(1'b1, 60, "rise1");
        wait_lvl(1'b0, 60, "fall1");
        wait_lvl(1'b1, 60, "rise2");
        wait_lvl(1'b0, 60, "fall2");
        wait_lvl(1'b1, 60, "rise3");

        // Illegal cfg_div=0: one cfg_err pulse, ratio unchanged, still ready
        err_q.push_back(1);
        push_edge(1'b0, 25); push_edge(1'b1, 25);
        cfg_valid = 1'b1;
        cfg_div   = '0;
        step(1);
        cfg_valid = 1'b0;
        check("err_pulse", int'(cfg_err), 1);
        check("err_ready", int'(cfg_ready), 1);
        step(1);
        check("err_clear", int'(cfg_err), 0);
        wait_lvl(1'b0, 60, "err_fall");
        wait_lvl(1'b1, 60, "err_rise");

        // Live reconfig to 4 while high: high phase finishes at 25, then 5-cycle halves
        push_edge(1'b0, 25); push_edge(1'b1, 5); push_edge(1'b0, 5);
        push_edge(1'b1, 5);  push_edge(1'b0, 5);
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(4);
        step(1);
        cfg_valid = 1'b0;
        check("reconf_ready_low", int'(cfg_ready), 0);
        step(10);
        check("reconf_ready_hold", int'(cfg_ready), 0);
        wait_lvl(1'b0, 40, "reconf_fall");
        check("reconf_ready_back", int'(cfg_ready), 1);
        wait_lvl(1'b1, 20, "new_rise1");
        wait_lvl(1'b0, 20, "new_fall1");
        wait_lvl(1'b1, 20, "new_rise2");
        wait_lvl(1'b0, 20, "new_fall2");

        // Stop while high: drain to the natural falling edge, then idle
        push_edge(1'b1, 5); push_edge(1'b0, 5);
        wait_lvl(1'b1, 20, "pre_stop_rise");
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("drain_busy", int'(busy), 1);
        check("drain_clk_high", int'(clk_out), 1);
        wait_lvl(1'b0, 20, "drain_fall");
        check("stopped_busy", int'(busy), 0);
        step(20);
        check("idle_busy", int'(busy), 0);
        check("idle_clk", int'(clk_out), 0);

        // start+stop together from IDLE stays idle
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", int'(busy), 0);
        step(5);
        check("ss_busy_later", int'(busy), 0);

        // Reset mid-RUN with clk_out high and a ratio pending
        push_edge(1'b1, 5);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_lvl(1'b1, 20, "pre_rst_rise");
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(7);
        step(1);
        cfg_valid = 1'b0;
        check("pre_rst_ready", int'(cfg_ready), 0);
        check("pre_rst_clk", int'(clk_out), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_clk", int'(clk_out), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_ready", int'(cfg_ready), 1);
        check("async_rst_tick", int'(tick), 0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // After reset the default ratio is back and the pending 7 is gone
        push_edge(1'b1, 25); push_edge(1'b0, 25);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_lvl(1'b1, 60, "post_rst_rise");
        wait_lvl(1'b0, 60, "post_rst_fall");
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("low_stop_busy", int'(busy), 0);

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
        // 300 rising edges with divide 1 (2-cycle halves): 8-bit counter wraps to 44
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(1);
        step(1);
        cfg_valid = 1'b0;
        check("idle_cfg_ready", int'(cfg_ready), 1);
        for (int i = 0; i < 300; i++) begin
            push_edge(1'b1, 2);
            push_edge(1'b0, 2);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("edge_cnt_cleared", int'(edge_cnt), 0);
        for (int i = 0; i < 300; i++) begin
            wait_lvl(1'b1, 10, "ec_rise");
            if (i < 299) wait_lvl(1'b0, 10, "ec_fall");
        end
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        wait_lvl(1'b0, 10, "ec_drain_fall");
        check("ec_busy", int'(busy), 0);
        check("edge_cnt_wrap", int'(edge_cnt), 44);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("edge_cnt_restart", int'(edge_cnt), 0);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("ec_final_busy", int'(busy), 0);
`endif

        step(5);
        check("edges_consumed", exp_q.size(), 0);
        check("errs_consumed", err_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
